// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register write-pending scoreboard for an in-order issue stage.
//
// Each architectural register has a small saturating counter of issued but
// not yet retired writes. Decode is stalled on a read-after-write hazard on
// any used source, or when the destination counter is already full.
//
// Optional feature macro: SB_RETIRE_BYPASS_EN
//   When defined, a source whose counter is 1 and which is being retired in
//   the same cycle is not treated as a hazard.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   reset          synchronous active-high reset
//   flush          zero all counters at the next edge (err_underflow kept)
//   issue_valid    decode presents an instruction
//   issue_writes   instruction writes issue_dst
//   issue_dst      destination register
//   issue_src_0/1/2 source registers
//   issue_src_used bit i set = source i is read
//   retire_valid   writeback commits a result this cycle
//   retire_dst     register being written back
//   stall          decode must hold (combinational)
//   pending_mask   bit i set = register i has pending writes
//   idle           no pending writes anywhere
//   err_underflow  sticky: retire seen for a register with counter 0

`ifndef REG_COUNT
`define REG_COUNT 16
`endif
`ifndef REG_PTR_SIZE
`define REG_PTR_SIZE 4
`endif

module reg_scoreboard #(
    parameter int unsigned REG_COUNT    = `REG_COUNT,
    parameter int unsigned REG_PTR_SIZE = `REG_PTR_SIZE,
    parameter int unsigned CNT_SIZE     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    issue_valid,
    input  logic                    issue_writes,
    input  logic [REG_PTR_SIZE-1:0] issue_dst,
    input  logic [REG_PTR_SIZE-1:0] issue_src_0,
    input  logic [REG_PTR_SIZE-1:0] issue_src_1,
    input  logic [REG_PTR_SIZE-1:0] issue_src_2,
    input  logic [2:0]              issue_src_used,
    input  logic                    retire_valid,
    input  logic [REG_PTR_SIZE-1:0] retire_dst,
    output logic                    stall,
    output logic [REG_COUNT-1:0]    pending_mask,
    output logic                    idle,
    output logic                    err_underflow
);

    localparam logic [CNT_SIZE-1:0] CNT_MAX = '1;
    localparam logic [CNT_SIZE-1:0] CNT_ONE = CNT_SIZE'(1);

    logic [CNT_SIZE-1:0] cnt_q [REG_COUNT];
    logic [CNT_SIZE-1:0] cnt_d [REG_COUNT];
    logic                err_q;
    logic                err_d;
    logic                stall_c;
    logic                accept;

    // Counter lookup; pointers with no matching register read as 0, which
    // makes out-of-range pointers non-hazards and never saturated.
    function automatic logic [CNT_SIZE-1:0] cnt_at(input logic [REG_PTR_SIZE-1:0] p);
        logic [CNT_SIZE-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (REG_PTR_SIZE'(i) == p) r = cnt_q[i];
        end
        return r;
    endfunction

    function automatic logic src_hazard(input logic used, input logic [REG_PTR_SIZE-1:0] src);
        logic [CNT_SIZE-1:0] c;
        logic                h;
        c = cnt_at(src);
        h = used && (c != '0);
`ifdef SB_RETIRE_BYPASS_EN
        // The last outstanding write lands this cycle, so the value is ready.
        if ((c == CNT_ONE) && retire_valid && (retire_dst == src)) h = 1'b0;
`endif
        return h;
    endfunction

    always_comb begin
        stall_c = 1'b0;
        if (issue_valid) begin
            stall_c = src_hazard(issue_src_used[0], issue_src_0)
                    | src_hazard(issue_src_used[1], issue_src_1)
                    | src_hazard(issue_src_used[2], issue_src_2)
                    | (issue_writes && (cnt_at(issue_dst) == CNT_MAX));
        end
        accept = issue_valid && !stall_c;
    end

    assign stall = stall_c;

    always_comb begin
        logic inc;
        logic ret;
        err_d = err_q;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            cnt_d[i] = cnt_q[i];
            inc = accept && issue_writes && (issue_dst == REG_PTR_SIZE'(i));
            ret = retire_valid && (retire_dst == REG_PTR_SIZE'(i));
            if (ret && (cnt_q[i] == '0)) err_d = 1'b1;
            // Issue and retire on the same register cancel out.
            if (inc && !ret && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (!inc && ret && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
        // Flush drops all pending state and ignores this cycle's issue/retire,
        // including any underflow that retire would have flagged.
        if (flush) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) cnt_d[i] = '0;
            err_d = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) cnt_q[i] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < REG_COUNT; i++) cnt_q[i] <= cnt_d[i];
            err_q <= err_d;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            pending_mask[i] = (cnt_q[i] != '0);
        end
    end

    assign idle          = (pending_mask == '0);
    assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic        issue_writes;
    logic [3:0]  issue_dst;
    logic [3:0]  issue_src_0;
    logic [3:0]  issue_src_1;
    logic [3:0]  issue_src_2;
    logic [2:0]  issue_src_used;
    logic        retire_valid;
    logic [3:0]  retire_dst;
    logic        stall;
    logic [15:0] pending_mask;
    logic        idle;
    logic        err_underflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic        stall;
        logic [15:0] mask;
        logic        idle;
        logic        err;
    } exp_t;

    exp_t sbq[$];

    reg_scoreboard #(
        .REG_COUNT   (16),
        .REG_PTR_SIZE(4),
        .CNT_SIZE    (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_writes  (issue_writes),
        .issue_dst     (issue_dst),
        .issue_src_0   (issue_src_0),
        .issue_src_1   (issue_src_1),
        .issue_src_2   (issue_src_2),
        .issue_src_used(issue_src_used),
        .retire_valid  (retire_valid),
        .retire_dst    (retire_dst),
        .stall         (stall),
        .pending_mask  (pending_mask),
        .idle          (idle),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        flush          = 1'b0;
        issue_valid    = 1'b0;
        issue_writes   = 1'b0;
        issue_dst      = '0;
        issue_src_0    = '0;
        issue_src_1    = '0;
        issue_src_2    = '0;
        issue_src_used = '0;
        retire_valid   = 1'b0;
        retire_dst     = '0;
    endtask

    task automatic issue_wr(input logic [3:0] dst);
        issue_valid  = 1'b1;
        issue_writes = 1'b1;
        issue_dst    = dst;
    endtask

    task automatic retire(input logic [3:0] dst);
        retire_valid = 1'b1;
        retire_dst   = dst;
    endtask

    // Push the expectation for the current inputs, then compare on the falling edge.
    task automatic chk(input string tag, input logic s, input logic [15:0] m,
                       input logic i, input logic e);
        exp_t x;
        x.tag = tag; x.stall = s; x.mask = m; x.idle = i; x.err = e;
        sbq.push_back(x);
        @(negedge clk);
        x = sbq.pop_front();
        total++;
        assert (stall === x.stall) else begin
            bad++;
            $error("FAIL %s.stall observed=%0b expected=%0b", x.tag, stall, x.stall);
        end
        total++;
        assert (pending_mask === x.mask) else begin
            bad++;
            $error("FAIL %s.pending_mask observed=%h expected=%h", x.tag, pending_mask, x.mask);
        end
        total++;
        assert (idle === x.idle) else begin
            bad++;
            $error("FAIL %s.idle observed=%0b expected=%0b", x.tag, idle, x.idle);
        end
        total++;
        assert (err_underflow === x.err) else begin
            bad++;
            $error("FAIL %s.err_underflow observed=%0b expected=%0b", x.tag, err_underflow, x.err);
        end
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset", 1'b0, 16'h0000, 1'b1, 1'b0);

        // RAW hazard on R3
        tick();
        issue_wr(4'd3);
        chk("raw_issue", 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        quiet();
        issue_valid = 1'b1; issue_src_0 = 4'd3; issue_src_used = 3'b001;
        chk("raw_stall", 1'b1, 16'h0008, 1'b0, 1'b0);
        tick();
        chk("raw_hold", 1'b1, 16'h0008, 1'b0, 1'b0);
        tick();
        retire(4'd3);
`ifdef SB_RETIRE_BYPASS_EN
        chk("raw_retire", 1'b0, 16'h0008, 1'b0, 1'b0);
`else
        chk("raw_retire", 1'b1, 16'h0008, 1'b0, 1'b0);
`endif
        tick();
        retire_valid = 1'b0;
        chk("raw_after", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Saturation on R5
        tick();
        quiet();
        issue_wr(4'd5);
        chk("sat_w1", 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        chk("sat_w2", 1'b0, 16'h0020, 1'b0, 1'b0);
        tick();
        chk("sat_w3", 1'b0, 16'h0020, 1'b0, 1'b0);
        tick();
        chk("sat_full", 1'b1, 16'h0020, 1'b0, 1'b0);
        tick();
        retire(4'd5);
        chk("sat_full_ret", 1'b1, 16'h0020, 1'b0, 1'b0);
        tick();
        retire_valid = 1'b0;
        chk("sat_w4", 1'b0, 16'h0020, 1'b0, 1'b0);
        tick();
        issue_valid = 1'b0;
        chk("sat_novalid", 1'b0, 16'h0020, 1'b0, 1'b0);
        tick();
        issue_valid = 1'b1;
        chk("sat_full_again", 1'b1, 16'h0020, 1'b0, 1'b0);
        tick();
        quiet();
        retire(4'd5);
        tick();
        tick();
        chk("sat_drain2", 1'b0, 16'h0020, 1'b0, 1'b0);
        tick();
        retire_valid = 1'b0;
        chk("sat_drained", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Simultaneous issue and retire on R7
        tick();
        issue_wr(4'd7);
        tick();
        retire(4'd7);
        chk("simul_drive", 1'b0, 16'h0080, 1'b0, 1'b0);
        tick();
        quiet();
        chk("simul_kept", 1'b0, 16'h0080, 1'b0, 1'b0);
        tick();
        retire(4'd7);
        tick();
        retire_valid = 1'b0;
        chk("simul_drained", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Underflow on R2, sticky through flush, cleared by reset
        tick();
        retire(4'd2);
        tick();
        retire_valid = 1'b0;
        chk("uflow", 1'b0, 16'h0000, 1'b1, 1'b1);
        tick();
        issue_wr(4'd2);
        tick();
        quiet();
        flush = 1'b1;
        chk("uflow_preflush", 1'b0, 16'h0004, 1'b0, 1'b1);
        tick();
        flush = 1'b0;
        chk("uflow_flushed", 1'b0, 16'h0000, 1'b1, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("uflow_reset", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush mid-operation with concurrent issue and retire
        tick();
        issue_wr(4'd1);
        tick();
        tick();
        issue_dst = 4'd4;
        tick();
        quiet();
        chk("flush_pre", 1'b0, 16'h0012, 1'b0, 1'b0);
        tick();
        flush = 1'b1;
        issue_wr(4'd9);
        retire(4'd1);
        chk("flush_drive", 1'b0, 16'h0012, 1'b0, 1'b0);
        tick();
        quiet();
        chk("flush_done", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Reset with writes pending discards that cycle's issue and retire
        tick();
        issue_wr(4'd6);
        tick();
        reset = 1'b1;
        retire(4'd0);
        chk("rst_mid_pre", 1'b0, 16'h0040, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        quiet();
        chk("rst_mid_post", 1'b0, 16'h0000, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter REG_COUNT, default `REG_COUNT (16), number of tracked registers.
REQ-002 SHALL have parameter REG_PTR_SIZE, default `REG_PTR_SIZE (4), register pointer width.
REQ-003 SHALL have parameter CNT_SIZE, default 2, per-register pending-counter width; CNT_MAX = 2^CNT_SIZE-1.
REQ-004 SHALL have ports:
- clk  in  1  clock; single clock domain, all state updates on rising edge.
- reset  in  1  reset; synchronous, active-high.
- flush  in  1  clears all pending state.
- issue_valid  in  1  decode stage presents an instruction.
- issue_writes  in  1  instruction writes issue_dst.
- issue_dst  in  REG_PTR_SIZE  destination register.
- issue_src_0 / issue_src_1 / issue_src_2  in  REG_PTR_SIZE each  source registers.
- issue_src_used  in  3  bit i set = source i read.
- retire_valid  in  1  writeback commits a result this cycle.
- retire_dst  in  REG_PTR_SIZE  register being written back.
- stall  out  1  decode must hold; instruction not accepted.
- pending_mask  out  REG_COUNT  bit i set = register i has pending writes.
- idle  out  1  no pending writes anywhere.
- err_underflow  out  1  sticky: retire seen for register with counter 0.

Function
REQ-005 SHALL keep one CNT_SIZE-bit counter per register holding the number of issued but unretired writes.
REQ-006 SHALL assert stall combinationally when issue_valid=1 and any used source has a hazard (counter != 0), or issue_writes=1 and the counter of issue_dst equals CNT_MAX.
REQ-007 SHALL assert stall=0 whenever issue_valid=0.
REQ-008 SHALL accept an issue when issue_valid=1 and stall=0; if issue_writes=1, counter[issue_dst] increments at the next rising edge (one-cycle latency).
REQ-009 SHALL decrement counter[retire_dst] at the next rising edge on retire_valid=1 when the counter is non-zero.
REQ-010 SHALL leave a counter unchanged when an accepted issue and a retire target the same register in the same cycle.
REQ-011 SHALL, on retire_valid=1 with counter[retire_dst]=0, leave the counter at 0 and set err_underflow, which then holds until reset.
REQ-012 SHALL never wrap any counter past CNT_MAX or below 0.
REQ-013 SHALL drive pending_mask[i] = (counter[i] != 0) and idle = (pending_mask == 0), both derived from registered state only.
REQ-014 SHALL, on flush=1, zero all counters at the next edge, ignoring same-cycle issue and retire; err_underflow is unaffected.
REQ-015 SHALL give reset priority over flush, and flush priority over issue/retire.
REQ-016 SHALL treat out-of-range pointers (>= REG_COUNT) as no-ops for counter update and as non-hazard for stall.

Reset
REQ-017 SHALL on reset=1 clear all counters to 0 and err_underflow to 0 at the next edge; post-reset: stall=0, pending_mask=0, idle=1, err_underflow=0.
REQ-018 SHALL discard any issue or retire presented in a reset cycle, including mid-operation with writes pending.

Configuration
REQ-019 SHALL use macro SB_RETIRE_BYPASS_EN: when defined, a source whose counter is 1 and which is being retired in the same cycle (retire_valid=1, retire_dst match) is not a hazard, so the issue is accepted the same cycle; when undefined, that source stalls until the counter reads 0 (one extra cycle).
REQ-020 SHALL leave all other behaviour identical with and without SB_RETIRE_BYPASS_EN.

Verification
REQ-021 Reset then idle: reset 1 cycle -> pending_mask=0, idle=1, stall=0, err_underflow=0.
REQ-022 RAW hazard: issue write R3, next cycle issue reading R3 (src_used=001) -> stall=1 until retire R3; with SB_RETIRE_BYPASS_EN the retire cycle gives stall=0, without it stall drops one cycle later.
REQ-023 Saturation: three accepted writes to R5, no retire -> counter=3, fourth write to R5 gives stall=1; one retire R5 -> fourth accepted next cycle.
REQ-024 Simultaneous: R7 counter=1, accepted issue to R7 and retire R7 same cycle -> counter stays 1, pending_mask[7]=1.
REQ-025 Underflow: retire R2 with counter 0 -> err_underflow=1, pending_mask[2]=0; err persists through flush, clears only on reset.
REQ-026 Flush mid-operation: R1=2, R4=1, flush with concurrent issue to R9 -> next cycle pending_mask=0, idle=1, R9 not pending.
